// File: rtl/data_mem_responder_if.sv
// ============================================================================
// data_mem_responder_if : memory-stage <-> data-memory request/response bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface data_mem_responder_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  req_valid;
    logic                  req_write;
    logic [15:0]           req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  req_ready;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_err;
    logic                  stall;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, stall
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err, stall
    );
endinterface

`default_nettype wire

// File: rtl/data_mem_responder.sv
// ============================================================================
// data_mem_responder : word-addressed RAM responder with programmable wait states
// Rev 1.0
// ============================================================================
`default_nettype none

module data_mem_responder #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus
);
    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_busy = 2'd1;
    localparam logic [1:0] c_resp = 2'd2;
    localparam logic [3:0] c_wait = 4'(WAIT_STATES);

    logic [1:0]            r_state;
    logic [1:0]            w_next;
    logic [3:0]            r_cnt;
    logic                  r_write;
    logic [15:0]           r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_resp_valid;
    logic [DATA_WIDTH-1:0] r_resp_rdata;
    logic                  r_resp_err;
    logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];

    logic                  w_ready;
    logic                  w_accept;
    logic                  w_from_busy;
    logic                  w_commit;
    logic                  w_c_write;
    logic [15:0]           w_c_addr;
    logic [DATA_WIDTH-1:0] w_c_wdata;
    logic                  w_oor;
    logic [ADDR_WIDTH-1:0] w_idx;

    assign w_ready     = (r_state == c_idle) || (r_state == c_resp);
    assign w_accept    = w_ready && bus.req_valid;
    assign w_from_busy = (r_state == c_busy) && (r_cnt <= 4'd1);
    // With zero wait states the access commits on the accepting edge, straight from the bus.
    assign w_commit    = w_from_busy || (w_accept && (c_wait == 4'd0));
    assign w_c_write   = (r_state == c_busy) ? r_write : bus.req_write;
    assign w_c_addr    = (r_state == c_busy) ? r_addr  : bus.req_addr;
    assign w_c_wdata   = (r_state == c_busy) ? r_wdata : bus.req_wdata;
    assign w_oor       = (w_c_addr >> ADDR_WIDTH) != 16'd0;
    assign w_idx       = w_c_addr[ADDR_WIDTH-1:0];

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_idle, c_resp: begin
                if (w_accept)
                    w_next = (c_wait == 4'd0) ? c_resp : c_busy;
                else
                    w_next = c_idle;
            end
            c_busy: begin
                if (w_from_busy)
                    w_next = c_resp;
            end
            default: w_next = c_idle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= c_idle;
            r_cnt        <= 4'd0;
            r_write      <= 1'b0;
            r_addr       <= 16'd0;
            r_wdata      <= '0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_resp_valid <= w_commit;
            if (w_accept) begin
                r_cnt   <= c_wait;
                r_write <= bus.req_write;
                r_addr  <= bus.req_addr;
                r_wdata <= bus.req_wdata;
            end else if ((r_state == c_busy) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_commit) begin
                r_resp_err   <= w_oor;
                r_resp_rdata <= (w_c_write || w_oor) ? '0 : r_mem[w_idx];
            end else begin
                r_resp_err   <= 1'b0;
            end
        end
    end

    // RAM contents survive reset; an out-of-range store never touches the array.
    always_ff @(posedge clk) begin
        if (w_commit && w_c_write && !w_oor && !reset)
            r_mem[w_idx] <= w_c_wdata;
    end

    assign bus.req_ready  = w_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.resp_err   = r_resp_err;
    assign bus.stall      = ((r_state == c_idle) && bus.req_valid) ||
                            (r_state == c_busy) ||
                            ((r_state == c_resp) && bus.req_valid);
endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// ============================================================================
// tb_data_mem_responder : scoreboard bench for a 2-wait-state and a 0-wait-state responder
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_data_mem_responder;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    data_mem_responder_if #(.DATA_WIDTH(16)) ifa();
    data_mem_responder_if #(.DATA_WIDTH(16)) ifb();

    data_mem_responder #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .WAIT_STATES(2)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa));
    data_mem_responder #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .WAIT_STATES(0)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb));

    typedef struct {
        int          due;
        logic [15:0] rdata;
        logic        err;
    } exp_t;

    typedef struct {
        logic        write;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        logic        err;
    } vec_t;

    exp_t        q[$];
    vec_t        vecs[13];
    vec_t        bursts[6];
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;
    logic        last_acc;
    logic [15:0] cur_rdata;
    logic        cur_err;

    function automatic logic f_req_valid(int sel);
        return (sel == 0) ? ifa.req_valid : ifb.req_valid;
    endfunction
    function automatic logic f_ready(int sel);
        return (sel == 0) ? ifa.req_ready : ifb.req_ready;
    endfunction
    function automatic logic f_resp_valid(int sel);
        return (sel == 0) ? ifa.resp_valid : ifb.resp_valid;
    endfunction
    function automatic logic [15:0] f_rdata(int sel);
        return (sel == 0) ? ifa.resp_rdata : ifb.resp_rdata;
    endfunction
    function automatic logic f_err(int sel);
        return (sel == 0) ? ifa.resp_err : ifb.resp_err;
    endfunction
    function automatic logic f_stall(int sel);
        return (sel == 0) ? ifa.stall : ifb.stall;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic flag(string name, string what);
        tests++;
        fails++;
        $display("FAIL %s: got %s", name, what);
    endtask

    task automatic drive(int sel, logic v, logic w, logic [15:0] a, logic [15:0] d,
                         logic [15:0] er, logic ee);
        if (sel == 0) begin
            ifa.req_valid = v; ifa.req_write = w; ifa.req_addr = a; ifa.req_wdata = d;
        end else begin
            ifb.req_valid = v; ifb.req_write = w; ifb.req_addr = a; ifb.req_wdata = d;
        end
        cur_rdata = er;
        cur_err   = ee;
    endtask

    // One clock edge: push the expectation of an accepted request, then score any response.
    task automatic step(int sel);
        int   ws;
        exp_t e;
        ws       = (sel == 0) ? 2 : 0;
        last_acc = f_req_valid(sel) && f_ready(sel);
        @(posedge clk);
        #1;
        cyc++;
        if (last_acc)
            q.push_back('{cyc + ws, cur_rdata, cur_err});
        if (f_resp_valid(sel)) begin
            if (q.size() == 0) begin
                flag("unexpected_resp", "resp_valid with nothing outstanding");
            end else begin
                e = q.pop_front();
                check("resp_cycle", cyc, e.due);
                check("resp_rdata", {16'd0, f_rdata(sel)}, {16'd0, e.rdata});
                check("resp_err", {31'd0, f_err(sel)}, {31'd0, e.err});
                check("stall_in_resp", {31'd0, f_stall(sel)}, {31'd0, f_req_valid(sel)});
                check("ready_in_resp", {31'd0, f_ready(sel)}, 32'd1);
            end
        end else if ((q.size() != 0) && (cyc >= q[0].due)) begin
            flag("missing_resp", "no resp_valid when due");
            void'(q.pop_front());
        end
    endtask

    task automatic xact(int sel, vec_t v);
        int n;
        drive(sel, 1'b1, v.write, v.addr, v.wdata, v.rdata, v.err);
        #1;
        check("ready_idle", {31'd0, f_ready(sel)}, 32'd1);
        check("stall_req_pending", {31'd0, f_stall(sel)}, 32'd1);
        n = 0;
        last_acc = 1'b0;
        while (!last_acc && n < 20) begin
            step(sel);
            n++;
        end
        if (!last_acc) flag("accept_timeout", "request never accepted");
        drive(sel, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 1'b0);
        #1;
        if (sel == 0) begin
            check("stall_busy", {31'd0, f_stall(sel)}, 32'd1);
            check("ready_busy", {31'd0, f_ready(sel)}, 32'd0);
        end
        n = 0;
        while (q.size() != 0 && n < 20) begin
            step(sel);
            n++;
        end
        if (q.size() != 0) begin
            flag("drain_timeout", "response outstanding after cycle budget");
            q.delete();
        end
    endtask

    initial begin
        int n;
        vecs[0]  = '{1'b1, 16'h0000, 16'h0F0F, 16'h0000, 1'b0};
        vecs[1]  = '{1'b1, 16'h0004, 16'hAAAA, 16'h0000, 1'b0};
        vecs[2]  = '{1'b0, 16'h0004, 16'h0000, 16'hAAAA, 1'b0};
        vecs[3]  = '{1'b1, 16'h0400, 16'h5555, 16'h0000, 1'b1};
        vecs[4]  = '{1'b0, 16'h0400, 16'h0000, 16'h0000, 1'b1};
        vecs[5]  = '{1'b0, 16'h0000, 16'h0000, 16'h0F0F, 1'b0};
        vecs[6]  = '{1'b1, 16'h0020, 16'h1111, 16'h0000, 1'b0};
        vecs[7]  = '{1'b0, 16'h0020, 16'h0000, 16'h1111, 1'b0};
        vecs[8]  = '{1'b1, 16'h03FF, 16'h2222, 16'h0000, 1'b0};
        vecs[9]  = '{1'b0, 16'h03FF, 16'h0000, 16'h2222, 1'b0};
        vecs[10] = '{1'b1, 16'h83FF, 16'h7777, 16'h0000, 1'b1};
        vecs[11] = '{1'b0, 16'h03FF, 16'h0000, 16'h2222, 1'b0};
        vecs[12] = '{1'b0, 16'h8000, 16'h0000, 16'h0000, 1'b1};

        bursts[0] = '{1'b1, 16'h0100, 16'h0001, 16'h0000, 1'b0};
        bursts[1] = '{1'b1, 16'h0101, 16'h0002, 16'h0000, 1'b0};
        bursts[2] = '{1'b0, 16'h0100, 16'h0000, 16'h0001, 1'b0};
        bursts[3] = '{1'b0, 16'h0101, 16'h0000, 16'h0002, 1'b0};
        bursts[4] = '{1'b1, 16'h0400, 16'h0009, 16'h0000, 1'b1};
        bursts[5] = '{1'b0, 16'h0100, 16'h0000, 16'h0001, 1'b0};

        // Reset held two cycles with a request pending on both responders.
        reset = 1'b1;
        drive(0, 1'b1, 1'b0, 16'h0004, 16'h0000, 16'h0000, 1'b0);
        drive(1, 1'b1, 1'b0, 16'h0004, 16'h0000, 16'h0000, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            check("rst_ready", {31'd0, f_ready(s)}, 32'd1);
            check("rst_resp_valid", {31'd0, f_resp_valid(s)}, 32'd0);
            check("rst_rdata", {16'd0, f_rdata(s)}, 32'd0);
            check("rst_err", {31'd0, f_err(s)}, 32'd0);
            check("rst_stall", {31'd0, f_stall(s)}, 32'd1);
        end
        drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        drive(1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        #1;
        check("idle_stall_low", {31'd0, f_stall(0)}, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 13; i++)
            xact(0, vecs[i]);

        // Back-to-back: the load is presented and accepted during the store's response cycle.
        drive(0, 1'b1, 1'b1, 16'h0010, 16'h1234, 16'h0000, 1'b0);
        #1;
        step(0);
        n = 0;
        while (!f_resp_valid(0) && n < 10) begin
            step(0);
            n++;
        end
        drive(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 16'h1234, 1'b0);
        #1;
        check("b2b_ready", {31'd0, f_ready(0)}, 32'd1);
        check("b2b_stall", {31'd0, f_stall(0)}, 32'd1);
        step(0);
        check("b2b_accept", {31'd0, last_acc}, 32'd1);
        drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        n = 0;
        while (q.size() != 0 && n < 10) begin
            step(0);
            n++;
        end
        if (q.size() != 0) begin
            flag("b2b_drain", "load response never arrived");
            q.delete();
        end

        // Reset while BUSY aborts the store and suppresses its response.
        drive(0, 1'b1, 1'b1, 16'h0020, 16'hBEEF, 16'h0000, 1'b0);
        #1;
        step(0);
        drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        step(0);
        reset = 1'b1;
        q.delete();
        #1;
        check("midrst_resp_valid", {31'd0, f_resp_valid(0)}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("midrst_no_resp", {31'd0, f_resp_valid(0)}, 32'd0);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_after_no_resp", {31'd0, f_resp_valid(0)}, 32'd0);
        xact(0, '{1'b0, 16'h0020, 16'h0000, 16'h1111, 1'b0});

        // Zero-wait-state responder: single accesses then an unbroken stream.
        xact(1, '{1'b1, 16'h0005, 16'hCAFE, 16'h0000, 1'b0});
        xact(1, '{1'b0, 16'h0005, 16'h0000, 16'hCAFE, 1'b0});
        for (int i = 0; i < 6; i++) begin
            drive(1, 1'b1, bursts[i].write, bursts[i].addr, bursts[i].wdata,
                  bursts[i].rdata, bursts[i].err);
            #1;
            check("burst_ready", {31'd0, f_ready(1)}, 32'd1);
            step(1);
            check("burst_resp_every_cycle", {31'd0, f_resp_valid(1)}, 32'd1);
        end
        drive(1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        #1;
        step(1);
        check("burst_end_idle", {31'd0, f_resp_valid(1)}, 32'd0);
        if (q.size() != 0) begin
            flag("burst_leftover", "responses still outstanding");
            q.delete();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

`default_nettype wire
